// File: rtl/ped_walk_scheduler.sv
// ped_walk_scheduler: latches pedestrian crosswalk requests and serves them
// in round-robin order. Each service asks the light controller to park in
// all-red, then runs a WALK / flashing don't-walk / clearance sequence for
// the granted crosswalk.
module ped_walk_scheduler #(
  parameter int WALK_CYC  = 8,
  parameter int FLASH_CYC = 4,
  parameter int CLEAR_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ped_btn,
  input  logic       tlc_hold_ack,
  output logic       hold_req,
  output logic [3:0] walk,
  output logic [3:0] flash,
  output logic [3:0] pending,
  output logic [7:0] served_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WALK,
    S_FLASH,
    S_CLEAR
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] timer_reg, timer_next;
  logic [1:0] grant_reg, grant_next;
  logic [1:0] last_grant_reg, last_grant_next;
  logic [3:0] pending_reg, pending_next;
  logic [7:0] served_reg, served_next;
  logic [1:0] rr_sel;

  // One-hot decodes of the round-robin pick, the current grant and the
  // grant the next cycle will show on the outputs.
  logic [3:0] rr_oh;
  logic [3:0] grant_oh;
  logic [3:0] grant_next_oh;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_onehot
      assign rr_oh[gi]         = (rr_sel     == 2'(gi));
      assign grant_oh[gi]      = (grant_reg  == 2'(gi));
      assign grant_next_oh[gi] = (grant_next == 2'(gi));
    end
  endgenerate

  // Round-robin search: start just after the last grant and wrap; the
  // lowest offset with a pending bit wins, so scan offsets from high to low.
  always_comb begin
    rr_sel = last_grant_reg + 2'd1;
    for (int k = 3; k >= 0; k--) begin
      if (pending_reg[last_grant_reg + 2'(k + 1)]) begin
        rr_sel = last_grant_reg + 2'(k + 1);
      end
    end
  end

  // Next-state, timer, request latch and service counter.
  always_comb begin
    state_next      = state_reg;
    timer_next      = 4'd0;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    served_next     = served_reg;
    pending_next    = pending_reg | ped_btn;

    case (state_reg)
      S_IDLE: begin
        if (pending_reg != 4'd0) begin
          state_next = S_REQ;
        end
      end

      S_REQ: begin
        if (tlc_hold_ack) begin
          state_next      = S_WALK;
          grant_next      = rr_sel;
          last_grant_next = rr_sel;
          // Clearing wins over a coincident press on the granted bit.
          pending_next    = (pending_reg | ped_btn) & ~rr_oh;
        end
      end

      S_WALK: begin
        // The crosswalk currently walking cannot re-request itself.
        pending_next = pending_reg | (ped_btn & ~grant_oh);
        if (!tlc_hold_ack || (timer_reg == 4'(WALK_CYC - 1))) begin
          state_next = S_FLASH;
        end else begin
          timer_next = timer_reg + 4'd1;
        end
      end

      S_FLASH: begin
        if (timer_reg == 4'(FLASH_CYC - 1)) begin
          state_next = S_CLEAR;
        end else begin
          timer_next = timer_reg + 4'd1;
        end
      end

      S_CLEAR: begin
        if (timer_reg == 4'(CLEAR_CYC - 1)) begin
          state_next  = S_IDLE;
          served_next = (served_reg == 8'hFF) ? served_reg : served_reg + 8'd1;
        end else begin
          timer_next = timer_reg + 4'd1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State registers plus Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      timer_reg      <= 4'd0;
      grant_reg      <= 2'd0;
      last_grant_reg <= 2'd3;
      pending_reg    <= 4'd0;
      served_reg     <= 8'd0;
      hold_req       <= 1'b0;
      walk           <= 4'd0;
      flash          <= 4'd0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      pending_reg    <= pending_next;
      served_reg     <= served_next;
      hold_req       <= (state_next != S_IDLE);
      walk           <= (state_next == S_WALK)  ? grant_next_oh : 4'd0;
      flash          <= (state_next == S_FLASH) ? grant_next_oh : 4'd0;
    end
  end

  assign pending    = pending_reg;
  assign served_cnt = served_reg;

endmodule
